// File: rtl/pid_pwm_out.sv
// PWM output stage for the pid loop: duty register, PWM pin drive, per-period tick (PID_PWM_DEADTIME_EN adds complementary dead-band drive).
// Latency: pwm_out follows cnt by 1 cycle (2 with dead-band); new duty takes effect only at the period wrap.
// Backpressure: none; duty strobes are always accepted, and a later strobe within the same period overwrites an earlier one.
module pid_pwm_out #(
    parameter int unsigned PERIOD = 1000,
    parameter int unsigned DEAD   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        duty_valid,
    input  logic [15:0] duty_in,
    output logic        pwm_out,
    output logic        pwm_out_n,
    output logic        period_end,
    output logic        duty_loaded
);

    localparam logic [15:0] PER16  = 16'(PERIOD);
    localparam logic [15:0] LAST16 = 16'(PERIOD - 1);
    localparam logic [15:0] DEAD16 = 16'(DEAD);

    if (PERIOD < 2 || PERIOD > 65535 || DEAD < 1) begin : g_bad_param
        $error("pid_pwm_out: PERIOD or DEAD out of range");
    end

    logic [15:0] cnt;
    logic [15:0] active;
    logic [15:0] pending;
    logic        pend_vld;
    logic        raw_q;
    logic        loaded_q;
    logic        wrap;

    assign wrap = (cnt == LAST16);

    function automatic logic [15:0] clamp_duty(input logic [15:0] d);
        return (d > PER16) ? PER16 : d;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            active   <= '0;
            pending  <= '0;
            pend_vld <= 1'b0;
            raw_q    <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            cnt      <= wrap ? '0 : cnt + 16'd1;
            raw_q    <= (cnt < active);
            loaded_q <= 1'b0;
            if (wrap) begin
                // Active duty only ever changes here; a strobe on this very cycle wins over the pending value.
                pend_vld <= 1'b0;
                if (duty_valid) begin
                    active   <= clamp_duty(duty_in);
                    loaded_q <= 1'b1;
                end else if (pend_vld) begin
                    active   <= clamp_duty(pending);
                    loaded_q <= 1'b1;
                end
            end else if (duty_valid) begin
                pending  <= duty_in;
                pend_vld <= 1'b1;
            end
        end
    end

    assign period_end  = wrap;
    assign duty_loaded = loaded_q;

`ifdef PID_PWM_DEADTIME_EN
    if (DEAD > PERIOD / 2 - 1) begin : g_bad_dead
        $error("pid_pwm_out: DEAD must be at most PERIOD/2-1");
    end

    // Run lengths of raw_q at its current level, saturating at DEAD.
    logic [15:0] hi_run;
    logic [15:0] lo_run;
    logic        pwm_q;
    logic        pwm_n_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_run  <= '0;
            lo_run  <= '0;
            pwm_q   <= 1'b0;
            pwm_n_q <= 1'b0;
        end else begin
            hi_run  <= raw_q  ? ((hi_run < DEAD16) ? hi_run + 16'd1 : hi_run) : '0;
            lo_run  <= !raw_q ? ((lo_run < DEAD16) ? lo_run + 16'd1 : lo_run) : '0;
            pwm_q   <= raw_q  && (hi_run >= DEAD16);
            pwm_n_q <= !raw_q && (lo_run >= DEAD16);
        end
    end

    assign pwm_out   = pwm_q;
    assign pwm_out_n = pwm_n_q;
`else
    assign pwm_out   = raw_q;
    assign pwm_out_n = 1'b0;
`endif

endmodule

// File: tb/tb_pid_pwm_out.sv
// Bench for pid_pwm_out (PERIOD=10, DEAD=2): cycle model plus directed duty scenarios.
module tb_pid_pwm_out;

    localparam int P = 10;
    localparam int D = 2;
`ifdef PID_PWM_DEADTIME_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        duty_valid;
    logic [15:0] duty_in;
    logic        pwm_out;
    logic        pwm_out_n;
    logic        period_end;
    logic        duty_loaded;

    pid_pwm_out #(.PERIOD(P), .DEAD(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .duty_valid (duty_valid),
        .duty_in    (duty_in),
        .pwm_out    (pwm_out),
        .pwm_out_n  (pwm_out_n),
        .period_end (period_end),
        .duty_loaded(duty_loaded)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: position in period, active/pending duty, and a window of recent raw compare values.
    int m_cnt = 0, m_active = 0, m_pend = 0;
    bit m_flag = 0, m_loaded = 0, m_raw = 0, m_valid = 0, nr;
    bit hist[$];
    int e_pwm, e_pwm_n, e_pe, e_dl;

    function automatic bit window_all(input bit v);
        if (hist.size() < D + 1) return 1'b0;
        foreach (hist[i]) if (hist[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_active = 0; m_pend = 0; m_flag = 0; m_loaded = 0; m_raw = 0;
            hist.delete();
            m_valid = 1;
        end else begin
            hist.push_back(m_raw);
            if (hist.size() > D + 1) void'(hist.pop_front());
            nr = (m_cnt < m_active);
            m_loaded = 0;
            if (m_cnt == P - 1) begin
                if (duty_valid) begin
                    m_active = (int'(duty_in) > P) ? P : int'(duty_in);
                    m_loaded = 1;
                end else if (m_flag) begin
                    m_active = (m_pend > P) ? P : m_pend;
                    m_loaded = 1;
                end
                m_flag = 0;
            end else if (duty_valid) begin
                m_pend = int'(duty_in);
                m_flag = 1;
            end
            m_raw = nr;
            m_cnt = (m_cnt + 1) % P;
        end
        e_pe = (m_cnt == P - 1);
        e_dl = m_loaded;
        if (DB) begin
            e_pwm   = window_all(1'b1);
            e_pwm_n = window_all(1'b0);
        end else begin
            e_pwm   = m_raw;
            e_pwm_n = 0;
        end
        #1;
        if (m_valid) begin
            check("pwm_out", pwm_out, e_pwm);
            check("pwm_out_n", pwm_out_n, e_pwm_n);
            check("period_end", period_end, e_pe);
            check("duty_loaded", duty_loaded, e_dl);
            check("both_high", int'(pwm_out & pwm_out_n), 0);
        end
    end

    task automatic wait_cnt(input int v);
        int k = 0;
        while (m_cnt != v && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (m_cnt != v) check("wait_cnt_timeout", m_cnt, v);
    endtask

    task automatic strobe(input int d);
        duty_valid = 1'b1;
        duty_in    = 16'(d);
        @(negedge clk);
        duty_valid = 1'b0;
        duty_in    = 16'd0;
    endtask

    // Counts over one steady period starting at cnt=1 of the next full period.
    task automatic measure(input string name, input int exp_hi, input int exp_n, input int exp_bl);
        int hi = 0, lo_n = 0, bl = 0;
        wait_cnt(9);
        wait_cnt(1);
        for (int i = 0; i < P; i++) begin
            hi   += int'(pwm_out);
            lo_n += int'(pwm_out_n);
            bl   += int'(!pwm_out && !pwm_out_n);
            @(negedge clk);
        end
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_n_hi"}, lo_n, exp_n);
        check({name, "_both_low"}, bl, exp_bl);
    endtask

    task automatic load_at(input int c, input int d);
        wait_cnt(c);
        strobe(d);
        wait_cnt(9);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int first_pe, second_pe, pe_seen, hi, dl;
        rst = 1'b1; duty_valid = 1'b0; duty_in = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_pwm_out", pwm_out, 0);
        check("rst_pwm_out_n", pwm_out_n, 0);
        check("rst_period_end", period_end, 0);
        check("rst_duty_loaded", duty_loaded, 0);

        // Idle after reset: period_end at offsets 9 and 19, pwm stays low.
        rst = 1'b0;
        first_pe = -1; second_pe = -1; pe_seen = 0; hi = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            hi += int'(pwm_out);
            if (period_end) begin
                if (pe_seen == 0) first_pe = k;
                else if (pe_seen == 1) second_pe = k;
                pe_seen++;
            end
        end
        check("idle_first_period_end", first_pe, 9);
        check("idle_second_period_end", second_pe, 19);
        check("idle_pwm_high_count", hi, 0);

        // Duty 3 strobed at cnt=4: loads at the next wrap.
        wait_cnt(4);
        strobe(3);
        wait_cnt(9);
        @(negedge clk);
        check("duty3_loaded_pulse", duty_loaded, 1);
        measure("duty3", DB ? 1 : 3, DB ? 5 : 0, DB ? 4 : 7);

        load_at(2, 54321);
        measure("clamp", 10, 0, 0);
        load_at(2, 0);
        measure("zero", 0, DB ? 10 : 0, DB ? 0 : 10);

        // Two strobes in one period: last one wins.
        wait_cnt(2);
        strobe(2);
        wait_cnt(5);
        strobe(7);
        wait_cnt(9);
        @(negedge clk);
        measure("overwrite7", DB ? 5 : 7, DB ? 1 : 0, DB ? 4 : 3);

        // Strobe on the wrap cycle bypasses the pending register.
        wait_cnt(9);
        strobe(5);
        check("bypass_loaded_pulse", duty_loaded, 1);
        measure("bypass5", DB ? 3 : 5, DB ? 3 : 0, DB ? 4 : 5);
        measure("bypass5_hold", DB ? 3 : 5, DB ? 3 : 0, DB ? 4 : 5);

        // Reset mid-period with a pending duty: pending is discarded.
        wait_cnt(2);
        strobe(8);
        wait_cnt(6);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pwm_out", pwm_out, 0);
        check("midrst_pwm_out_n", pwm_out_n, 0);
        check("midrst_period_end", period_end, 0);
        check("midrst_duty_loaded", duty_loaded, 0);
        @(negedge clk);
        rst = 1'b0;
        hi = 0; dl = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            hi += int'(pwm_out);
            dl += int'(duty_loaded);
        end
        check("midrst_pwm_high_count", hi, 0);
        check("midrst_loaded_count", dl, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
